// File: rtl/irq_encoder8_if.sv
// rtl/irq_encoder8_if.sv - grant handshake between the request encoder and its controller
interface irq_encoder8_if #(
    parameter int N = 3
);
    logic [N-1:0] n;
    logic         valid;
    logic         ack;

    modport master (
        output n,
        output valid,
        input  ack
    );

    modport slave (
        input  n,
        input  valid,
        output ack
    );
endinterface

// File: rtl/irq_encoder8.sv
// rtl/irq_encoder8.sv - edge-latched request priority encoder with valid/ack grant handshake
module irq_encoder8 #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [2**N-1:0]   req,
    input  logic [2**N-1:0]   mask,
    input  logic              ena,
    input  logic              clr_lost,
    irq_encoder8_if.master    irq,
    output logic [2**N-1:0]   pend,
    output logic [2**N-1:0]   lost
);
    localparam int L = 2**N;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state;
    logic [L-1:0]   req_q;
    logic [L-1:0]   rise;
    logic [L-1:0]   cand;
    logic [L-1:0]   clr_vec;
    logic [L-1:0]   lost_set;
    logic [N-1:0]   sel;
    logic           take;

    assign take     = (state == PRESENT) && irq.ack;
    assign rise     = req & ~req_q;
    assign cand     = pend & ~mask;
    assign lost_set = rise & pend & ~clr_vec;

    always_comb begin
        clr_vec = '0;
        if (take) begin
            clr_vec[irq.n] = 1'b1;
        end
    end

    // Ascending scan: the last hit is the highest index, which has priority.
    always_comb begin
        sel = '0;
        for (int i = 0; i < L; i++) begin
            if (cand[i]) begin
                sel = N'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            req_q     <= '0;
            pend      <= '0;
            lost      <= '0;
            irq.n     <= '0;
            irq.valid <= 1'b0;
        end else begin
            req_q <= req;
            // A coincident rise re-arms the line being acknowledged.
            pend  <= (pend & ~clr_vec) | rise;
            lost  <= (clr_lost ? '0 : lost) | lost_set;
            case (state)
                IDLE: begin
                    if (ena && (cand != '0)) begin
                        irq.n     <= sel;
                        irq.valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq.ack) begin
                        irq.valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    irq.valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_encoder8.sv
// tb/tb_irq_encoder8.sv - directed-vector bench for irq_encoder8
module tb_irq_encoder8;
    logic       clk;
    logic       clrn;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ena;
    logic       clr_lost;
    logic [7:0] pend;
    logic [7:0] lost;

    int vectors;
    int miscompares;

    irq_encoder8_if #(.N(3)) bus ();

    irq_encoder8 #(.N(3)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .req      (req),
        .mask     (mask),
        .ena      (ena),
        .clr_lost (clr_lost),
        .irq      (bus.master),
        .pend     (pend),
        .lost     (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clrn     = 1'b0;
        req      = 8'h00;
        mask     = 8'h00;
        ena      = 1'b0;
        clr_lost = 1'b0;
        bus.ack  = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_n",     32'(bus.n),     32'd0);
        check("rst_pend",  32'(pend),      32'h00);
        check("rst_lost",  32'(lost),      32'h00);
        clrn = 1'b1;
        ena  = 1'b1;
        tick();

        // single request on line 2
        req = 8'h04;
        tick();
        check("t1_pend", 32'(pend), 32'h04);
        check("t1_nograntyet", 32'(bus.valid), 32'd0);
        req = 8'h00;
        tick();
        check("t1_valid", 32'(bus.valid), 32'd1);
        check("t1_n", 32'(bus.n), 32'd2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t1_ackvalid", 32'(bus.valid), 32'd0);
        check("t1_ackpend", 32'(pend), 32'h00);

        // lines 5 and 1 together
        req = 8'h22;
        tick();
        req = 8'h00;
        tick();
        check("t2_n5", 32'(bus.n), 32'd5);
        check("t2_v5", 32'(bus.valid), 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t2_idle", 32'(bus.valid), 32'd0);
        check("t2_pend", 32'(pend), 32'h02);
        tick();
        check("t2_n1", 32'(bus.n), 32'd1);
        check("t2_v1", 32'(bus.valid), 32'd1);

        // no preemption by line 7
        req = 8'h80;
        tick();
        req = 8'h00;
        check("t3_hold_n", 32'(bus.n), 32'd1);
        check("t3_pend", 32'(pend), 32'h82);
        tick();
        check("t3_hold_n2", 32'(bus.n), 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t3_pend_after", 32'(pend), 32'h80);
        tick();
        check("t3_n7", 32'(bus.n), 32'd7);
        check("t3_v7", 32'(bus.valid), 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t3_empty", 32'(pend), 32'h00);

        // masked line 7 waits behind line 0
        mask = 8'h80;
        req  = 8'h81;
        tick();
        req = 8'h00;
        check("t4_pend", 32'(pend), 32'h81);
        tick();
        check("t4_n0", 32'(bus.n), 32'd0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check("t4_masked", 32'(bus.valid), 32'd0);
        check("t4_still_pend", 32'(pend), 32'h80);
        mask = 8'h00;
        tick();
        check("t4_n7", 32'(bus.n), 32'd7);
        check("t4_v7", 32'(bus.valid), 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // global enable gating
        ena = 1'b0;
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        check("t5_blocked", 32'(bus.valid), 32'd0);
        check("t5_pend", 32'(pend), 32'h10);
        ena = 1'b1;
        tick();
        check("t5_n4", 32'(bus.n), 32'd4);
        check("t5_v4", 32'(bus.valid), 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // ack while idle is ignored and clears nothing
        ena = 1'b0;
        req = 8'h40;
        tick();
        req = 8'h00;
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t5b_idle_ack", 32'(pend), 32'h40);
        ena = 1'b1;
        tick();
        check("t5b_n6", 32'(bus.n), 32'd6);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // overrun on a pending, unpresented line
        ena = 1'b0;
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        check("t6_nolost", 32'(lost), 32'h00);
        req = 8'h08;
        tick();
        req = 8'h00;
        check("t6_lost", 32'(lost), 32'h08);
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("t6_clr_lost", 32'(lost), 32'h00);
        ena = 1'b1;
        tick();
        check("t6_n3", 32'(bus.n), 32'd3);
        check("t6_v3", 32'(bus.valid), 32'd1);
        req = 8'h08;
        bus.ack = 1'b1;
        tick();
        req = 8'h00;
        bus.ack = 1'b0;
        check("t6_setwins", 32'(pend), 32'h08);
        check("t6_nolost2", 32'(lost), 32'h00);
        check("t6_ackdone", 32'(bus.valid), 32'd0);
        tick();
        check("t6_regrant", 32'(bus.n), 32'd3);
        req = 8'h08;
        tick();
        req = 8'h00;
        check("t6_lost_pres", 32'(lost), 32'h08);

        // asynchronous reset mid-grant
        #2;
        clrn = 1'b0;
        #1;
        check("t7_valid", 32'(bus.valid), 32'd0);
        check("t7_pend", 32'(pend), 32'h00);
        check("t7_lost", 32'(lost), 32'h00);
        tick();
        clrn = 1'b1;
        tick();
        check("t7_stay_idle", 32'(bus.valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irq_encoder8.md
Name: irq_encoder8

Overview:
- Sequential 8-to-3 priority encoder with request latching and a valid/ack handshake.
- It is the inverse of the 3-to-8 enabled decoder. Eight request lines are edge-detected into sticky pending bits, and the highest-index unmasked pending line is presented as a binary index.
- It serves as the interrupt/request front end for the controller, which acknowledges each index in turn.

Parameters:
- N, 3, index width; the number of request lines is 2**N (default 8).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- clrn  input  1  asynchronous active-low reset
- req  input  2**N  request lines; a rising edge on bit i requests service of line i
- mask  input  2**N  bit i = 1 excludes line i from selection; the pending bit is still kept
- ena  input  1  global enable; 0 blocks new grants
- ack  input  1  controller accepts the presented index
- clr_lost  input  1  clears all lost flags
- n  output  N  presented index, highest priority = highest index
- valid  output  1  n is a live grant
- pend  output  2**N  pending register, for visibility
- lost  output  2**N  sticky per-line overrun flags

Behaviour:
- Reset (clrn = 0, asynchronous): req_q, pend, lost, n, valid are all 0; state IDLE.
- Edge detect: req_q <= req every cycle. rise = req & ~req_q.
- Pending update each edge: pend <= (pend & ~clr_vec) | rise.
  - clr_vec is one-hot at n when the ack is accepted, 0 otherwise.
  - Set wins over clear: if a rise on line n coincides with its accepted ack, pend[n] stays 1.
- Lost flags:
  - lost[i] <= 1 when rise[i] = 1 and pend[i] = 1 already, and line i is not being cleared this cycle.
  - clr_lost = 1 clears all lost bits. A same-cycle set wins over clr_lost.
- Candidate vector: cand = pend & ~mask. sel = index of the highest set bit of cand.
- State IDLE (valid = 0):
  - If ena = 1 and cand != 0: n <= sel, valid <= 1, go to PRESENT.
  - Else stay in IDLE; n holds its last value.
  - ack in IDLE is ignored.
- State PRESENT (valid = 1):
  - n is held stable regardless of ena, mask, or new higher-priority requests. There is no retraction or preemption.
  - On ack = 1: pend[n] is cleared (per the set-wins rule), valid <= 0, go to IDLE.
- Latency:
  - A rise seen at edge k sets pend at edge k, so pend is visible after edge k.
  - valid rises at edge k+1 at the earliest.
  - After an accepted ack, the next grant is at the earliest 1 cycle later. There is a mandatory single idle cycle: valid is 0 for at least one cycle between grants.
- Level-held request: a line held high does not re-request. A new rising edge is required after it goes low.
- Masked pending lines stay pending and are granted once unmasked (subject to priority at IDLE evaluation).
- Reset mid-grant: valid drops immediately (asynchronously), and all pending and lost state is discarded.
- pend and lost outputs are the registers directly, with no combinational path from req.

Test Plan:
- Reset, then pulse req = 8'h04 for 1 cycle with ena = 1, mask = 0 -> pend = 8'h04, then valid = 1, n = 2 one edge later. Ack -> valid = 0, pend = 0 next edge.
- req rises on 8'h22 simultaneously -> n = 5 first. Ack -> one idle cycle with valid = 0, then n = 1, valid = 1. Ack -> pend = 0.
- While presenting n = 1, raise req bit 7 -> n stays 1 until ack. Next grant is n = 7.
- mask = 8'h80, pend = 8'h81 -> grant n = 0. Clear mask after ack -> grant n = 7.
- ena = 0 with req = 8'h10 -> pend = 8'h10, valid stays 0. ena = 1 -> valid = 1, n = 4 one edge later.
- Line 3 pending (not presented); pulse req bit 3 again -> lost = 8'h08. clr_lost -> lost = 0. Coincident re-rise and ack on the presented line 3 -> pend[3] remains 1 and lost stays 0. Assert clrn = 0 mid-grant -> valid, pend, lost all 0 immediately.
